// File: rtl/fetch_unit_if.sv
// Fetch-side bus: instruction memory port, redirect input and the decode handshake.
// The master modport is the fetch stage; the slave modport is its environment.
interface fetch_unit_if;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        fault;

  modport master (
    output imem_addr,
    output out_valid,
    output out_instr,
    output out_pc,
    output fault,
    input  imem_instr,
    input  redirect_valid,
    input  redirect_pc,
    input  out_ready
  );

  modport slave (
    input  imem_addr,
    input  out_valid,
    input  out_instr,
    input  out_pc,
    input  fault,
    output imem_instr,
    output redirect_valid,
    output redirect_pc,
    output out_ready
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register, combinational imem lookup and a 2-entry
// {pc, instr} buffer toward decode, with redirect flush and sticky fetch fault.
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned IMEM_WORDS = 1024
) (
  input logic          clk,
  input logic          rst_n,
  fetch_unit_if.master bus
);

  localparam logic [0:0] StRun  = 1'b0;
  localparam logic [0:0] StHalt = 1'b1;

  logic [0:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [1:0]  count_q, count_d;
  logic        fault_q, fault_d;
  logic [31:0] head_pc_q, head_pc_d;
  logic [31:0] head_instr_q, head_instr_d;
  logic [31:0] tail_pc_q, tail_pc_d;
  logic [31:0] tail_instr_q, tail_instr_d;

  logic        run;
  logic        bad_pc;
  logic        redirect;
  logic        deq;
  logic        enq;
  logic [1:0]  wr_slot;

  assign bus.imem_addr = {2'b00, pc_q[31:2]};
  assign bus.out_valid = (count_q != 2'd0);
  assign bus.out_pc    = head_pc_q;
  assign bus.out_instr = head_instr_q;
  assign bus.fault     = fault_q;

  always_comb begin
    run      = (state_q == StRun);
    bad_pc   = (pc_q[1:0] != 2'b00) || ({2'b00, pc_q[31:2]} >= IMEM_WORDS);
    redirect = run && bus.redirect_valid;
    deq      = bus.out_valid && bus.out_ready;
    // A full buffer may still accept when the head leaves on the same edge.
    enq      = run && !redirect && !bad_pc && ((count_q != 2'd2) || deq);
    wr_slot  = count_q - {1'b0, deq};
  end

  always_comb begin
    state_d      = state_q;
    fault_d      = fault_q;
    pc_d         = pc_q;
    head_pc_d    = head_pc_q;
    head_instr_d = head_instr_q;
    tail_pc_d    = tail_pc_q;
    tail_instr_d = tail_instr_q;

    if (deq) begin
      head_pc_d    = tail_pc_q;
      head_instr_d = tail_instr_q;
    end

    if (enq) begin
      if (wr_slot == 2'd0) begin
        head_pc_d    = pc_q;
        head_instr_d = bus.imem_instr;
      end else begin
        tail_pc_d    = pc_q;
        tail_instr_d = bus.imem_instr;
      end
    end

    if (redirect) begin
      count_d = 2'd0;
      pc_d    = bus.redirect_pc;
    end else begin
      count_d = count_q + {1'b0, enq} - {1'b0, deq};
      if (enq) begin
        pc_d = pc_q + 32'd4;
      end
    end

    // A bad target of a redirect is caught here on the following cycle.
    if (run && !redirect && bad_pc) begin
      state_d = StHalt;
      fault_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StRun;
      fault_q      <= 1'b0;
      pc_q         <= RESET_PC;
      count_q      <= 2'd0;
      head_pc_q    <= 32'd0;
      head_instr_q <= 32'd0;
      tail_pc_q    <= 32'd0;
      tail_instr_q <= 32'd0;
    end else begin
      state_q      <= state_d;
      fault_q      <= fault_d;
      pc_q         <= pc_d;
      count_q      <= count_d;
      head_pc_q    <= head_pc_d;
      head_instr_q <= head_instr_d;
      tail_pc_q    <= tail_pc_d;
      tail_instr_q <= tail_instr_d;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized scoreboard bench for fetch_unit, plus a small directed check of a second
// instance whose reset PC is the last word of a 16-word memory.
module tb_fetch_unit;

  localparam int unsigned W1   = 64;
  localparam int unsigned W2   = 16;
  localparam logic [31:0] RPC2 = 32'(4 * (W2 - 1));

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  fetch_unit_if bus ();
  fetch_unit_if bus2 ();

  assign bus.imem_instr  = bus.imem_addr ^ 32'hA5A5_0000;
  assign bus2.imem_instr = bus2.imem_addr ^ 32'hA5A5_0000;

  fetch_unit #(
    .RESET_PC  (32'h0000_0000),
    .IMEM_WORDS(W1)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  fetch_unit #(
    .RESET_PC  (RPC2),
    .IMEM_WORDS(W2)
  ) dut2 (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus2)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: expected buffer contents as {pc, instr}, next fetch PC, fault flag.
  logic [63:0] mq[$];
  logic [31:0] mpc    = 32'h0;
  logic        mfault = 1'b0;

  function automatic logic [31:0] mem_word(input logic [31:0] byte_addr);
    return (byte_addr / 4) ^ 32'hA5A5_0000;
  endfunction

  function automatic bit bad_addr(input logic [31:0] a);
    return ((a % 4) != 0) || ((a / 4) >= W1);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model step: the monitor has already retired any head accepted this cycle.
  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      mq.delete();
      mpc    = 32'h0;
      mfault = 1'b0;
    end else if (!mfault) begin
      if (bus.redirect_valid) begin
        mq.delete();
        mpc = bus.redirect_pc;
      end else if (bad_addr(mpc)) begin
        mfault = 1'b1;
      end else if (mq.size() < 2) begin
        mq.push_back({mpc, mem_word(mpc)});
        mpc = mpc + 32'd4;
      end
    end
  end

  // Monitor: compare the presented outputs mid-cycle, pop the head on a handshake.
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_fault", 32'(bus.fault), 32'd0);
      chk("rst_out_pc", bus.out_pc, 32'd0);
      chk("rst_out_instr", bus.out_instr, 32'd0);
    end else begin
      chk("out_valid", 32'(bus.out_valid), 32'(mq.size() != 0));
      chk("fault", 32'(bus.fault), 32'(mfault));
      chk("imem_addr", bus.imem_addr, mpc / 4);
      if (mq.size() != 0) begin
        chk("out_pc", bus.out_pc, mq[0][63:32]);
        chk("out_instr", bus.out_instr, mq[0][31:0]);
        if (bus.out_ready) void'(mq.pop_front());
      end
    end
  end

  task automatic drive(input logic rv, input logic [31:0] rpc, input logic rdy);
    @(posedge clk);
    #2;
    bus.redirect_valid = rv;
    bus.redirect_pc    = rpc;
    bus.out_ready      = rdy;
  endtask

  task automatic do_reset(input logic rdy);
    @(posedge clk);
    #2;
    rst_n              = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.out_ready      = rdy;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  // Reset asserted between edges must clear outputs before the next clock edge.
  task automatic async_reset_check(input string tag);
    @(posedge clk);
    #2;
    rst_n              = 1'b0;
    bus.redirect_valid = 1'b0;
    #1;
    chk({tag, "_valid"}, 32'(bus.out_valid), 32'd0);
    chk({tag, "_fault"}, 32'(bus.fault), 32'd0);
    chk({tag, "_pc"}, bus.out_pc, 32'd0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  // Second instance: a single fetch at the last word, then fault, entry still drains.
  initial begin
    bus2.redirect_valid = 1'b0;
    bus2.redirect_pc    = 32'h0;
    bus2.out_ready      = 1'b0;
    @(posedge rst_n);
    @(posedge clk);
    @(negedge clk);
    chk("end_valid1", 32'(bus2.out_valid), 32'd1);
    chk("end_pc1", bus2.out_pc, RPC2);
    chk("end_instr1", bus2.out_instr, mem_word(RPC2));
    chk("end_fault1", 32'(bus2.fault), 32'd0);
    @(negedge clk);
    chk("end_fault2", 32'(bus2.fault), 32'd1);
    chk("end_valid2", 32'(bus2.out_valid), 32'd1);
    chk("end_pc2", bus2.out_pc, RPC2);
    chk("end_addr2", bus2.imem_addr, 32'(W2));
    bus2.out_ready = 1'b1;
    @(negedge clk);
    chk("end_valid3", 32'(bus2.out_valid), 32'd0);
    chk("end_fault3", 32'(bus2.fault), 32'd1);
  end

  initial begin
    logic [31:0] tgt;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'h0;
    bus.out_ready      = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b1;

    // Stream from reset straight past the end of memory.
    repeat (W1 + 10) drive(1'b0, 32'h0, 1'b1);

    // Decode stalls five cycles, then drains in order.
    do_reset(1'b0);
    repeat (4) drive(1'b0, 32'h0, 1'b0);
    repeat (8) drive(1'b0, 32'h0, 1'b1);

    // Redirect while full with the head accepted in the same cycle.
    do_reset(1'b0);
    repeat (3) drive(1'b0, 32'h0, 1'b0);
    drive(1'b1, 32'h0000_0040, 1'b1);
    repeat (6) drive(1'b0, 32'h0, 1'b1);

    // Misaligned redirect faults; a later redirect is ignored until reset.
    drive(1'b1, 32'h0000_0042, 1'b1);
    repeat (4) drive(1'b0, 32'h0, 1'b1);
    drive(1'b1, 32'h0000_0000, 1'b1);
    repeat (4) drive(1'b0, 32'h0, 1'b1);
    chk("halt_fault", 32'(bus.fault), 32'd1);
    async_reset_check("async_halt");

    // Reset mid-stream with a valid head.
    repeat (6) drive(1'b0, 32'h0, 1'b1);
    async_reset_check("async_stream");
    repeat (4) drive(1'b0, 32'h0, 1'b1);

    repeat (3000) begin
      case ($urandom_range(0, 7))
        0:       tgt = 32'($urandom_range(0, 4 * W1)) | 32'($urandom_range(1, 3));
        1:       tgt = 32'(4 * (W1 - 1));
        2:       tgt = 32'hFFFF_FFFC;
        default: tgt = 32'(4 * $urandom_range(0, W1 - 1));
      endcase
      drive(($urandom_range(0, 11) == 0), tgt, ($urandom_range(0, 3) != 0));
      if (mfault && ($urandom_range(0, 7) == 0)) do_reset(1'b1);
    end

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
